morse_pattern_encoder: RTL and testbench

- Upstream feeder for tickspeed_blinker.
- Accepts ASCII characters over a valid/ready handshake, looks up each character's Morse code, and builds a MESSAGE_WIDTH-bit on/off pattern, one time unit per bit.
- Hands the finished pattern to the blinker's blink_pattern input, only on the blinker's START pulse, so a pattern never changes mid-playback.
- Holds up to two characters: one being built, one staged.

---
 rtl/morse_pattern_encoder.sv | 169 ++++++++++++++++
 tb/tb_morse_pattern_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_pattern_encoder.sv
// Morse pattern encoder: ASCII chars in over valid/ready, on/off unit
// patterns out to a blinker, swapped in only on the blinker's START pulse.
//   CLK, RST          clock, synchronous active-high reset
//   char_data/valid   ASCII input, char_ready accepts in IDLE only
//   START             blinker cycle start; loads blink_pattern
//   blink_pattern     pattern, bit 0 plays first
//   pending/busy      staged pattern waiting / builder active
//   bad_char          one-cycle pulse on a dropped unsupported char
module morse_pattern_encoder #(
  parameter int MESSAGE_WIDTH = 32,
  parameter bit REPEAT_LAST   = 1'b0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [7:0]               char_data,
  input  logic                     char_valid,
  output logic                     char_ready,
  input  logic                     START,
  output logic [MESSAGE_WIDTH-1:0] blink_pattern,
  output logic                     pending,
  output logic                     busy,
  output logic                     bad_char
);

  localparam int PW = $clog2(MESSAGE_WIDTH);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, ON, OFF, DONE
  } state_t;

  state_t                   state;
  logic [7:0]               ch;
  logic [2:0]               len_left;
  logic [4:0]               elems;
  logic [1:0]               unit_cnt;
  logic [PW-1:0]            ptr;
  logic [MESSAGE_WIDTH-1:0] build;
  logic [MESSAGE_WIDTH-1:0] staging;
  logic [8:0]               code_in;
  logic [8:0]               code_ch;

  // {supported, length, elements}; element 0 in bit 0, 1 = dash.
  // Space is supported with length 0.
  function automatic logic [8:0] lookup(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    case (u)
      8'h20: lookup = {1'b1, 3'd0, 5'b00000};
      "A":   lookup = {1'b1, 3'd2, 5'b00010};
      "B":   lookup = {1'b1, 3'd4, 5'b00001};
      "C":   lookup = {1'b1, 3'd4, 5'b00101};
      "D":   lookup = {1'b1, 3'd3, 5'b00001};
      "E":   lookup = {1'b1, 3'd1, 5'b00000};
      "F":   lookup = {1'b1, 3'd4, 5'b00100};
      "G":   lookup = {1'b1, 3'd3, 5'b00011};
      "H":   lookup = {1'b1, 3'd4, 5'b00000};
      "I":   lookup = {1'b1, 3'd2, 5'b00000};
      "J":   lookup = {1'b1, 3'd4, 5'b01110};
      "K":   lookup = {1'b1, 3'd3, 5'b00101};
      "L":   lookup = {1'b1, 3'd4, 5'b00010};
      "M":   lookup = {1'b1, 3'd2, 5'b00011};
      "N":   lookup = {1'b1, 3'd2, 5'b00001};
      "O":   lookup = {1'b1, 3'd3, 5'b00111};
      "P":   lookup = {1'b1, 3'd4, 5'b00110};
      "Q":   lookup = {1'b1, 3'd4, 5'b01011};
      "R":   lookup = {1'b1, 3'd3, 5'b00010};
      "S":   lookup = {1'b1, 3'd3, 5'b00000};
      "T":   lookup = {1'b1, 3'd1, 5'b00001};
      "U":   lookup = {1'b1, 3'd3, 5'b00100};
      "V":   lookup = {1'b1, 3'd4, 5'b01000};
      "W":   lookup = {1'b1, 3'd3, 5'b00110};
      "X":   lookup = {1'b1, 3'd4, 5'b01001};
      "Y":   lookup = {1'b1, 3'd4, 5'b01101};
      "Z":   lookup = {1'b1, 3'd4, 5'b00011};
      "0":   lookup = {1'b1, 3'd5, 5'b11111};
      "1":   lookup = {1'b1, 3'd5, 5'b11110};
      "2":   lookup = {1'b1, 3'd5, 5'b11100};
      "3":   lookup = {1'b1, 3'd5, 5'b11000};
      "4":   lookup = {1'b1, 3'd5, 5'b10000};
      "5":   lookup = {1'b1, 3'd5, 5'b00000};
      "6":   lookup = {1'b1, 3'd5, 5'b00001};
      "7":   lookup = {1'b1, 3'd5, 5'b00011};
      "8":   lookup = {1'b1, 3'd5, 5'b00111};
      "9":   lookup = {1'b1, 3'd5, 5'b01111};
      default: lookup = 9'd0;
    endcase
  endfunction

  assign code_in    = lookup(char_data);
  assign code_ch    = lookup(ch);
  assign char_ready = (state == IDLE) && !RST;
  assign busy       = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      ch            <= '0;
      len_left      <= '0;
      elems         <= '0;
      unit_cnt      <= '0;
      ptr           <= '0;
      build         <= '0;
      staging       <= '0;
      pending       <= 1'b0;
      blink_pattern <= '0;
      bad_char      <= 1'b0;
    end else begin
      bad_char <= 1'b0;

      if (START) begin
        if (pending) begin
          blink_pattern <= staging;
          pending       <= 1'b0;
        end else if (!REPEAT_LAST) begin
          blink_pattern <= '0;
        end
      end

      unique case (state)
        IDLE: begin
          if (char_valid) begin
            if (code_in[8]) begin
              ch    <= char_data;
              build <= '0;
              ptr   <= '0;
              state <= LOOKUP;
            end else begin
              bad_char <= 1'b1;
            end
          end
        end
        LOOKUP: begin
          len_left <= code_ch[7:5];
          elems    <= code_ch[4:0];
          unit_cnt <= '0;
          state    <= (code_ch[7:5] == 3'd0) ? DONE : ON;
        end
        ON: begin
          build[ptr] <= 1'b1;
          ptr        <= ptr + 1'b1;
          if (elems[0] && unit_cnt != 2'd2) begin
            unit_cnt <= unit_cnt + 2'd1;
          end else begin
            unit_cnt <= '0;
            elems    <= elems >> 1;
            len_left <= len_left - 3'd1;
            state    <= (len_left == 3'd1) ? DONE : OFF;
          end
        end
        OFF: begin
          build[ptr] <= 1'b0;
          ptr        <= ptr + 1'b1;
          state      <= ON;
        end
        DONE: begin
          // Staging frees up on this edge if START is draining it;
          // this set of pending overrides the clear above.
          if (!pending || START) begin
            staging <= build;
            pending <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_pattern_encoder.sv
// Scoreboard bench for morse_pattern_encoder; two instances run in
// lockstep, one per REPEAT_LAST setting.
module tb_morse_pattern_encoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  char_data = '0;
  logic        char_valid = 1'b0;
  logic        START = 1'b0;
  logic        rdy0, rdy1, pend0, pend1, busy0, busy1, bad0, bad1;
  logic [31:0] out0, out1;

  int n_vec = 0;
  int n_err = 0;
  int bad_cnt0 = 0;
  int bad_cnt1 = 0;

  logic [31:0] sb[$];
  logic [31:0] e0 = '0;
  logic [31:0] e1 = '0;

  always #5 CLK = ~CLK;

  morse_pattern_encoder #(.MESSAGE_WIDTH(32), .REPEAT_LAST(1'b0)) dut (
    .CLK(CLK), .RST(RST), .char_data(char_data),
    .char_valid(char_valid), .char_ready(rdy0), .START(START),
    .blink_pattern(out0), .pending(pend0), .busy(busy0),
    .bad_char(bad0)
  );

  morse_pattern_encoder #(.MESSAGE_WIDTH(32), .REPEAT_LAST(1'b1)) dut_rl (
    .CLK(CLK), .RST(RST), .char_data(char_data),
    .char_valid(char_valid), .char_ready(rdy1), .START(START),
    .blink_pattern(out1), .pending(pend1), .busy(busy1),
    .bad_char(bad1)
  );

  always @(negedge CLK) begin
    if (bad0) bad_cnt0++;
    if (bad1) bad_cnt1++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic p,
                           input logic r, input logic b);
    check({tag, "_pend"}, {31'd0, pend0}, {31'd0, p});
    check({tag, "_pend_rl"}, {31'd0, pend1}, {31'd0, p});
    check({tag, "_rdy"}, {31'd0, rdy0}, {31'd0, r});
    check({tag, "_rdy_rl"}, {31'd0, rdy1}, {31'd0, r});
    check({tag, "_busy"}, {31'd0, busy0}, {31'd0, b});
    check({tag, "_busy_rl"}, {31'd0, busy1}, {31'd0, b});
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    while (!rdy0 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("ready_timeout", {31'd0, rdy0}, 32'd1);
    char_data  = c;
    char_valid = 1'b1;
    step();
    char_valid = 1'b0;
  endtask

  task automatic wait_pending();
    int n;
    n = 0;
    while (!pend0 && n < 100) begin
      step();
      n++;
    end
    check("pend_timeout", {31'd0, pend0}, 32'd1);
  endtask

  task automatic latency(input string tag, input int k);
    repeat (k - 1) step();
    check({tag, "_lat_pre"}, {31'd0, pend0}, 32'd0);
    step();
    check({tag, "_lat"}, {31'd0, pend0}, 32'd1);
  endtask

  task automatic pulse(input string tag, input bit load);
    if (load) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e0 = sb.pop_front();
        e1 = e0;
      end
    end else begin
      e0 = '0;
    end
    START = 1'b1;
    step();
    START = 1'b0;
    check({tag, "_out"}, out0, e0);
    check({tag, "_out_rl"}, out1, e1);
  endtask

  logic [7:0]  tch[2]  = '{"S", "k"};
  logic [31:0] tpat[2] = '{32'h0000_0015, 32'h0000_01D7};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check("rst_rdy", {31'd0, rdy0}, 32'd0);
    check("rst_out", out0, 32'd0);
    RST = 1'b0;
    #1;
    chk_state("post_rst", 1'b0, 1'b1, 1'b0);

    repeat (2) begin
      repeat (63) step();
      pulse("idle", 1'b0);
    end
    check("idle_bad", bad_cnt0, 0);

    send("E");
    sb.push_back(32'h0000_0001);
    latency("E", 3);
    pulse("E", 1'b1);
    check("E_pend_after", {31'd0, pend0}, 32'd0);

    send("a");
    sb.push_back(32'h0000_001D);
    latency("A", 7);
    send("T");
    sb.push_back(32'h0000_0007);
    repeat (8) step();
    chk_state("T_hold", 1'b1, 1'b0, 1'b1);
    pulse("AT1", 1'b1);
    check("AT1_pend", {31'd0, pend0}, 32'd1);
    pulse("AT2", 1'b1);
    check("AT2_pend", {31'd0, pend0}, 32'd0);

    send("0");
    sb.push_back(32'h0007_7777);
    latency("zero", 21);
    pulse("zero", 1'b1);

    send("#");
    check("bad_pulse", {31'd0, bad0}, 32'd1);
    check("bad_pulse_rl", {31'd0, bad1}, 32'd1);
    step();
    check("bad_clear", {31'd0, bad0}, 32'd0);
    chk_state("bad", 1'b0, 1'b1, 1'b0);
    pulse("bad", 1'b0);
    check("bad_cnt", bad_cnt0, 1);
    check("bad_cnt_rl", bad_cnt1, 1);

    send(8'h20);
    sb.push_back(32'h0);
    latency("space", 2);
    pulse("space", 1'b1);

    for (int i = 0; i < 2; i++) begin
      send(tch[i]);
      sb.push_back(tpat[i]);
      wait_pending();
      pulse("tbl", 1'b1);
    end

    send("E");
    sb.push_back(32'h0000_0001);
    wait_pending();
    send("B");
    sb.push_back(32'h0000_0157);
    step();
    step();
    check("B_busy", {31'd0, busy0}, 32'd1);
    RST = 1'b1;
    step();
    check("mid_rst_rdy", {31'd0, rdy0}, 32'd0);
    check("mid_rst_out", out0, 32'd0);
    check("mid_rst_out_rl", out1, 32'd0);
    RST = 1'b0;
    sb.delete();
    e0 = '0;
    e1 = '0;
    #1;
    chk_state("mid_rst", 1'b0, 1'b1, 1'b0);
    pulse("post_rst", 1'b0);
    check("final_bad", bad_cnt0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
